ps2_key_controller: RTL and testbench

PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_timeout_ctr.sv | 42 ++++
 rtl/ps2_key_controller.sv | 190 +++++++++++++++++++
 tb/tb_ps2_key_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 key controller:
//   - ps2_state_e : scan-code parser states
//   - PS2_*       : scan-code byte constants
//   - is_flush_code() : true for BAT / keyboard error bytes that drop all keys
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_SPACE  = 8'h29;
  localparam logic [7:0] PS2_UP     = 8'h75;
  localparam logic [7:0] PS2_DOWN   = 8'h72;
  localparam logic [7:0] PS2_ENTER  = 8'h5A;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ERR_FC = 8'hFC;
  localparam logic [7:0] PS2_ERR_FF = 8'hFF;

  // A keyboard self-test or error report means we no longer know which keys are down.
  function automatic logic is_flush_code(input logic [7:0] code);
    return (code == PS2_BAT) || (code == PS2_ERR_FC) || (code == PS2_ERR_FF);
  endfunction

endpackage

// File: rtl/ps2_timeout_ctr.sv
// ---------------------------------------------------------------------------
// ps2_timeout_ctr
// Idle-cycle counter with synchronous clear and count enable. tc is high
// while the count equals LIMIT-1; the count holds there until cleared.
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset (count -> 0)
//   clear  : synchronous clear, dominates enable
//   enable : count one per cycle while high
//   tc     : terminal count reached
// ---------------------------------------------------------------------------
module ps2_timeout_ctr #(
  parameter int unsigned LIMIT = 50000
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned   CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_r;

  assign tc = (cnt_r == LAST);

  // Idle-cycle count: clear on request, advance while enabled, saturate at LAST.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && !tc) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ps2_key_controller.sv
// ---------------------------------------------------------------------------
// ps2_key_controller
// Parses PS/2 set-2 scan-code bytes into game controls.
// Ports:
//   clk         : system clock, all state on rising edge
//   resetN      : asynchronous active-low reset
//   rx_valid    : one-cycle strobe, rx_data carries a received byte
//   rx_data     : received scan-code byte
//   rx_error    : one-cycle strobe, receiver framing/parity error
//   jump_pulse  : one-cycle pulse on a fresh Space or Up make
//   duck_held   : high while Down is held
//   start_pulse : one-cycle pulse on a fresh Enter make
//   seq_error   : one-cycle pulse on rx_error, timeout or illegal prefix
// All outputs are registered and update one cycle after the final byte.
// ---------------------------------------------------------------------------
module ps2_key_controller
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic       jump_pulse,
  output logic       duck_held,
  output logic       start_pulse,
  output logic       seq_error
);

  ps2_state_e state_r;
  logic       space_held_r, up_held_r, down_held_r, enter_held_r;

  logic byte_ok_s, is_ext_s, is_brk_s, is_prefix_s;
  logic mk_space_s, mk_up_s, mk_down_s, mk_enter_s;
  logic bk_space_s, bk_up_s, bk_down_s, bk_enter_s;
  logic flush_s, illegal_s, timeout_s, abort_s, tmo_tc_s;
  logic space_nxt_s, up_nxt_s, down_nxt_s, enter_nxt_s;

  // A byte arriving together with rx_error is discarded.
  assign byte_ok_s   = rx_valid & ~rx_error;
  assign is_ext_s    = (rx_data == PS2_EXT);
  assign is_brk_s    = (rx_data == PS2_BRK);
  assign is_prefix_s = is_ext_s | is_brk_s;

  ps2_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .resetN (resetN),
    .clear  (rx_valid | rx_error | (state_r == ST_IDLE)),
    .enable (state_r != ST_IDLE),
    .tc     (tmo_tc_s)
  );

  // Classify the current byte against the parser state into make/break/flush events.
  always_comb begin
    mk_space_s = 1'b0;
    mk_up_s    = 1'b0;
    mk_down_s  = 1'b0;
    mk_enter_s = 1'b0;
    bk_space_s = 1'b0;
    bk_up_s    = 1'b0;
    bk_down_s  = 1'b0;
    bk_enter_s = 1'b0;
    flush_s    = 1'b0;
    illegal_s  = 1'b0;
    if (byte_ok_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!is_prefix_s) begin
            mk_space_s = (rx_data == PS2_SPACE);
            mk_enter_s = (rx_data == PS2_ENTER);
            flush_s    = is_flush_code(rx_data);
          end else begin
            illegal_s = 1'b0;
          end
        end
        ST_EXT: begin
          if (is_ext_s) begin
            illegal_s = 1'b1;
          end else if (!is_brk_s) begin
            mk_up_s   = (rx_data == PS2_UP);
            mk_down_s = (rx_data == PS2_DOWN);
          end else begin
            illegal_s = 1'b0;
          end
        end
        ST_BRK: begin
          if (is_prefix_s) begin
            illegal_s = 1'b1;
          end else begin
            bk_space_s = (rx_data == PS2_SPACE);
            bk_enter_s = (rx_data == PS2_ENTER);
          end
        end
        ST_EXT_BRK: begin
          if (is_prefix_s) begin
            illegal_s = 1'b1;
          end else begin
            bk_up_s   = (rx_data == PS2_UP);
            bk_down_s = (rx_data == PS2_DOWN);
          end
        end
        default: begin
          illegal_s = 1'b0;
        end
      endcase
    end else begin
      illegal_s = 1'b0;
    end
  end

  // Timeout only counts when no byte or error is competing for this cycle.
  assign timeout_s = tmo_tc_s & ~rx_valid & ~rx_error & (state_r != ST_IDLE);
  assign abort_s   = rx_error | illegal_s | timeout_s;

  // Next value of each held flag: flush beats make, make beats break.
  always_comb begin
    space_nxt_s = space_held_r;
    up_nxt_s    = up_held_r;
    down_nxt_s  = down_held_r;
    enter_nxt_s = enter_held_r;
    if (flush_s) begin
      space_nxt_s = 1'b0;
      up_nxt_s    = 1'b0;
      down_nxt_s  = 1'b0;
      enter_nxt_s = 1'b0;
    end else begin
      space_nxt_s = mk_space_s | (space_held_r & ~bk_space_s);
      up_nxt_s    = mk_up_s    | (up_held_r    & ~bk_up_s);
      down_nxt_s  = mk_down_s  | (down_held_r  & ~bk_down_s);
      enter_nxt_s = mk_enter_s | (enter_held_r & ~bk_enter_s);
    end
  end

  // Parser FSM, held-key flags and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= ST_IDLE;
      space_held_r <= 1'b0;
      up_held_r    <= 1'b0;
      down_held_r  <= 1'b0;
      enter_held_r <= 1'b0;
      jump_pulse   <= 1'b0;
      duck_held    <= 1'b0;
      start_pulse  <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      space_held_r <= space_nxt_s;
      up_held_r    <= up_nxt_s;
      down_held_r  <= down_nxt_s;
      enter_held_r <= enter_nxt_s;
      duck_held    <= down_nxt_s;
      // Pulse only on the first make; typematic repeats see the flag already set.
      jump_pulse   <= (mk_space_s | mk_up_s) & ~space_held_r & ~up_held_r;
      start_pulse  <= mk_enter_s & ~enter_held_r;
      seq_error    <= abort_s;
      if (abort_s) begin
        state_r <= ST_IDLE;
      end else if (byte_ok_s) begin
        case (state_r)
          ST_IDLE: begin
            if (is_ext_s) begin
              state_r <= ST_EXT;
            end else if (is_brk_s) begin
              state_r <= ST_BRK;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_EXT: begin
            if (is_brk_s) begin
              state_r <= ST_EXT_BRK;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_BRK:     state_r <= ST_IDLE;
          ST_EXT_BRK: state_r <= ST_IDLE;
          default:    state_r <= ST_IDLE;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_controller.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_controller
// Directed scan-code sequences; every strobe pushes its hand-computed
// expected outputs {jump, duck, start, seq_error} into a queue that a
// separate monitor pops one cycle later. Between strobes the monitor checks
// that the pulses are low and duck_held is unchanged.
// ---------------------------------------------------------------------------
module tb_ps2_key_controller;

  localparam int unsigned TMO = 50000;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_error = 1'b0;
  logic       jump_pulse, duck_held, start_pulse, seq_error;

  typedef struct {
    logic [3:0] exp;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   vec_id = 0;
  logic strobe_seen = 1'b0;

  ps2_key_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_error    (rx_error),
    .jump_pulse  (jump_pulse),
    .duck_held   (duck_held),
    .start_pulse (start_pulse),
    .seq_error   (seq_error)
  );

  always #5 clk = ~clk;

  // Drive one byte strobe; e = expected {jump, duck, start, seq_error} one cycle later.
  task automatic send(input logic [7:0] b, input logic [3:0] e);
    exp_t t;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t.exp = e;
    t.id  = vec_id;
    vec_id++;
    exp_q.push_back(t);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Drive an rx_error strobe, optionally together with a byte.
  task automatic send_err(input logic with_byte, input logic [7:0] b, input logic [3:0] e);
    exp_t t;
    @(negedge clk);
    rx_error = 1'b1;
    rx_valid = with_byte;
    rx_data  = b;
    t.exp = e;
    t.id  = vec_id;
    vec_id++;
    exp_q.push_back(t);
    @(negedge clk);
    rx_error = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Record whether the DUT consumed a strobe on this edge.
  initial begin
    forever begin
      @(posedge clk);
      strobe_seen = rx_valid | rx_error;
    end
  end

  // Monitor: pop and compare after each strobe, otherwise check quiet outputs.
  initial begin
    exp_t       e;
    logic [3:0] got;
    logic       last_duck;
    last_duck = 1'b0;
    forever begin
      @(negedge clk);
      got = {jump_pulse, duck_held, start_pulse, seq_error};
      if (!resetN) begin
        last_duck = 1'b0;
      end else if (strobe_seen) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL scoreboard_empty: got %b with no expected entry", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e.exp) begin
            n_miss++;
            $display("FAIL vec%0d {jump,duck,start,seq}: got %b expected %b", e.id, got, e.exp);
          end
          last_duck = e.exp[2];
        end
      end else begin
        n_vec++;
        if (jump_pulse !== 1'b0 || start_pulse !== 1'b0 || duck_held !== last_duck) begin
          n_miss++;
          $display("FAIL idle_quiet t=%0t: jump=%b start=%b duck=%b expected 0 0 %b",
                   $time, jump_pulse, start_pulse, duck_held, last_duck);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({jump_pulse, duck_held, start_pulse, seq_error} !== 4'b0000) begin
      n_miss++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {jump_pulse, duck_held, start_pulse, seq_error});
    end
    resetN = 1'b1;

    // Space make then break: one pulse, nothing on break.
    send(8'h29, 4'b1000); send(8'hF0, 4'b0000); send(8'h29, 4'b0000);
    // Typematic: one pulse only, then re-press after release pulses again.
    send(8'h29, 4'b1000); send(8'h29, 4'b0000); send(8'h29, 4'b0000);
    send(8'hF0, 4'b0000); send(8'h29, 4'b0000);
    send(8'h29, 4'b1000); send(8'hF0, 4'b0000); send(8'h29, 4'b0000);
    // Up make pulses; Space while Up held does not.
    send(8'hE0, 4'b0000); send(8'h75, 4'b1000); send(8'h29, 4'b0000);
    send(8'hF0, 4'b0000); send(8'h29, 4'b0000);
    send(8'hE0, 4'b0000); send(8'hF0, 4'b0000); send(8'h75, 4'b0000);
    send(8'h29, 4'b1000); send(8'hF0, 4'b0000); send(8'h29, 4'b0000);
    // Down held / released.
    send(8'hE0, 4'b0000); send(8'h72, 4'b0100);
    send(8'hE0, 4'b0100); send(8'hF0, 4'b0100); send(8'h72, 4'b0000);
    // Enter with repeat and re-press.
    send(8'h5A, 4'b0010); send(8'h5A, 4'b0000); send(8'hF0, 4'b0000);
    send(8'h5A, 4'b0000); send(8'h5A, 4'b0010); send(8'hF0, 4'b0000);
    send(8'h5A, 4'b0000);
    // Illegal prefixes.
    send(8'hE0, 4'b0000); send(8'hE0, 4'b0001);
    send(8'hF0, 4'b0000); send(8'hF0, 4'b0001);
    send(8'hF0, 4'b0000); send(8'hE0, 4'b0001);
    send(8'hE0, 4'b0000); send(8'hF0, 4'b0000); send(8'hE0, 4'b0001);
    send(8'hE0, 4'b0000); send(8'hF0, 4'b0000); send(8'hF0, 4'b0001);
    send(8'h29, 4'b1000); send(8'hF0, 4'b0000); send(8'h29, 4'b0000);
    // Receiver errors: error wins over a simultaneous byte.
    send_err(1'b0, 8'h00, 4'b0001);
    send_err(1'b1, 8'h29, 4'b0001);
    send(8'hE0, 4'b0000); send_err(1'b0, 8'h00, 4'b0001);
    send(8'h29, 4'b1000); send(8'hF0, 4'b0000); send(8'h29, 4'b0000);
    // Flush codes clear held keys.
    send(8'hE0, 4'b0000); send(8'h72, 4'b0100); send(8'hAA, 4'b0000);
    send(8'hE0, 4'b0000); send(8'h72, 4'b0100); send(8'hFC, 4'b0000);
    send(8'hE0, 4'b0000); send(8'h72, 4'b0100); send(8'hFF, 4'b0000);
    send(8'h29, 4'b1000); send(8'hAA, 4'b0000); send(8'h29, 4'b1000);
    send(8'hF0, 4'b0000); send(8'h29, 4'b0000);
    // Unlisted code is ignored.
    send(8'h1C, 4'b0000); send(8'hF0, 4'b0000); send(8'h1C, 4'b0000);

    // Timeout after E0 with Down held: flags survive, parser returns to IDLE.
    send(8'hE0, 4'b0000); send(8'h72, 4'b0100);
    send(8'hE0, 4'b0100);
    cnt = 0;
    while (seq_error !== 1'b1 && cnt < 60000) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (seq_error !== 1'b1 || cnt != TMO) begin
      n_miss++;
      $display("FAIL timeout_latency: seq_error=%b after %0d cycles, expected 1 after %0d",
               seq_error, cnt, TMO);
    end
    @(negedge clk);
    n_vec++;
    if (seq_error !== 1'b0) begin
      n_miss++;
      $display("FAIL timeout_pulse_width: seq_error=%b expected 0", seq_error);
    end
    send(8'h5A, 4'b0110); send(8'hF0, 4'b0100); send(8'h5A, 4'b0100);
    send(8'hE0, 4'b0100); send(8'hF0, 4'b0100); send(8'h72, 4'b0000);

    // Reset mid-sequence discards E0 and clears Down.
    send(8'hE0, 4'b0000); send(8'h72, 4'b0100); send(8'hE0, 4'b0100);
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({jump_pulse, duck_held, start_pulse, seq_error} !== 4'b0000) begin
      n_miss++;
      $display("FAIL midseq_reset: got %b expected 0000",
               {jump_pulse, duck_held, start_pulse, seq_error});
    end
    resetN = 1'b1;
    send(8'h72, 4'b0000);
    send(8'h29, 4'b1000);

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
